// File: rtl/spi_flash_arbiter_if.sv
// SPI bus bundle between the two SPI masters, the shared flash and the arbiter.
// The master modport is the board side (masters plus flash). The slave modport is the arbiter.
interface spi_flash_arbiter_if;
    logic dsp_cs_INV;
    logic dsp_clk;
    logic dsp_mosi;
    logic dsp_miso;
    logic cpu_cs_INV;
    logic cpu_clk;
    logic cpu_mosi;
    logic cpu_miso;
    logic flash_cs_INV;
    logic flash_clk;
    logic flash_mosi;
    logic flash_miso;

    modport master (
        output dsp_cs_INV, dsp_clk, dsp_mosi,
        input  dsp_miso,
        output cpu_cs_INV, cpu_clk, cpu_mosi,
        input  cpu_miso,
        input  flash_cs_INV, flash_clk, flash_mosi,
        output flash_miso
    );

    modport slave (
        input  dsp_cs_INV, dsp_clk, dsp_mosi,
        output dsp_miso,
        input  cpu_cs_INV, cpu_clk, cpu_mosi,
        output cpu_miso,
        output flash_cs_INV, flash_clk, flash_mosi,
        input  flash_miso
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Shares the SPI boot/config flash between the DSP and CPU SPI masters.
// One owner at a time. The owner's raw SCLK/MOSI/CS pass straight through to the flash.
// Ownership is decided on synchronised chip selects, and a guard gap keeps the flash
// deselected between owners.
module spi_flash_arbiter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned GUARD_CYCLES  = 4,
    parameter int unsigned TIMEOUT_WIDTH = 20,
    parameter int unsigned PRIORITY      = 0
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      enable,
    spi_flash_arbiter_if.slave        bus,
    output logic [1:0]                grant,
    output logic                      collision,
    output logic                      timeout,
    output logic [7:0]                collision_count
);

    localparam int unsigned GUARD_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [TIMEOUT_WIDTH-1:0] OWN_ONES = '1;
    // The counter clears on grant. Reaching ONES-1 therefore means the owner has held the flash for 2**W-1 cycles.
    localparam logic [TIMEOUT_WIDTH-1:0] OWN_LAST = OWN_ONES - TIMEOUT_WIDTH'(1);
    localparam logic DSP_WINS = (PRIORITY == 0);

    typedef enum logic [1:0] {
        IDLE,
        OWN_DSP,
        OWN_CPU,
        GUARD
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   dsp_sync;
    logic [SYNC_STAGES-1:0]   cpu_sync;
    logic                     req_dsp;
    logic                     req_cpu;
    logic                     req_dsp_q;
    logic                     req_cpu_q;
    logic                     rise_dsp;
    logic                     rise_cpu;
    logic                     denied_dsp;
    logic                     denied_cpu;
    logic                     elig_dsp;
    logic                     elig_cpu;
    logic [TIMEOUT_WIDTH-1:0] own_cnt;
    logic [GUARD_W-1:0]       guard_cnt;
    logic                     to_dsp;
    logic                     to_cpu;
    logic                     deny_dsp_set;
    logic                     deny_cpu_set;
    logic                     coll_set;

    // Bring both chip selects into the sysclk domain; flops idle high (deselected).
    always_ff @(posedge sysclk) begin
        if (reset) begin
            dsp_sync <= '1;
            cpu_sync <= '1;
        end else begin
            dsp_sync <= {dsp_sync[SYNC_STAGES-2:0], bus.dsp_cs_INV};
            cpu_sync <= {cpu_sync[SYNC_STAGES-2:0], bus.cpu_cs_INV};
        end
    end

    assign req_dsp  = ~dsp_sync[SYNC_STAGES-1];
    assign req_cpu  = ~cpu_sync[SYNC_STAGES-1];
    assign rise_dsp = req_dsp & ~req_dsp_q;
    assign rise_cpu = req_cpu & ~req_cpu_q;
    assign elig_dsp = req_dsp & ~denied_dsp;
    assign elig_cpu = req_cpu & ~denied_cpu;
    assign to_dsp   = enable && (state == OWN_DSP) && req_dsp && (own_cnt == OWN_LAST);
    assign to_cpu   = enable && (state == OWN_CPU) && req_cpu && (own_cnt == OWN_LAST);

    // Work out who gets denied this cycle and whether that counts as a collision.
    always_comb begin
        deny_dsp_set = 1'b0;
        deny_cpu_set = 1'b0;
        coll_set     = 1'b0;
        if (!enable) begin
            deny_dsp_set = req_dsp;
            deny_cpu_set = req_cpu;
        end else begin
            if (state != IDLE) begin
                if (rise_dsp) begin
                    deny_dsp_set = 1'b1;
                    coll_set     = 1'b1;
                end
                if (rise_cpu) begin
                    deny_cpu_set = 1'b1;
                    coll_set     = 1'b1;
                end
            end else if (elig_dsp && elig_cpu) begin
                coll_set = 1'b1;
                if (DSP_WINS) begin
                    deny_cpu_set = 1'b1;
                end else begin
                    deny_dsp_set = 1'b1;
                end
            end
            if (to_dsp) begin
                deny_dsp_set = 1'b1;
            end
            if (to_cpu) begin
                deny_cpu_set = 1'b1;
            end
        end
    end

    // Ownership FSM with registered grant, pulses, deny flags and collision counter.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state           <= IDLE;
            grant           <= 2'b00;
            own_cnt         <= '0;
            guard_cnt       <= '0;
            req_dsp_q       <= 1'b0;
            req_cpu_q       <= 1'b0;
            denied_dsp      <= 1'b0;
            denied_cpu      <= 1'b0;
            collision       <= 1'b0;
            timeout         <= 1'b0;
            collision_count <= '0;
        end else begin
            req_dsp_q  <= req_dsp;
            req_cpu_q  <= req_cpu;
            // Deny flags clear whenever the request is low. They can only be set while it is high.
            denied_dsp <= req_dsp & (denied_dsp | deny_dsp_set);
            denied_cpu <= req_cpu & (denied_cpu | deny_cpu_set);
            collision  <= coll_set;
            timeout    <= to_dsp | to_cpu;
            if (coll_set && (collision_count != 8'hFF)) begin
                collision_count <= collision_count + 8'd1;
            end

            if (!enable) begin
                state     <= IDLE;
                grant     <= 2'b00;
                own_cnt   <= '0;
                guard_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        own_cnt <= '0;
                        if (elig_dsp && (!elig_cpu || DSP_WINS)) begin
                            state <= OWN_DSP;
                            grant <= 2'b01;
                        end else if (elig_cpu) begin
                            state <= OWN_CPU;
                            grant <= 2'b10;
                        end
                    end
                    OWN_DSP: begin
                        if (!req_dsp || to_dsp) begin
                            state     <= GUARD;
                            grant     <= 2'b00;
                            guard_cnt <= GUARD_W'(GUARD_CYCLES);
                        end else begin
                            own_cnt <= own_cnt + TIMEOUT_WIDTH'(1);
                        end
                    end
                    OWN_CPU: begin
                        if (!req_cpu || to_cpu) begin
                            state     <= GUARD;
                            grant     <= 2'b00;
                            guard_cnt <= GUARD_W'(GUARD_CYCLES);
                        end else begin
                            own_cnt <= own_cnt + TIMEOUT_WIDTH'(1);
                        end
                    end
                    GUARD: begin
                        grant <= 2'b00;
                        if (guard_cnt <= GUARD_W'(1)) begin
                            state     <= IDLE;
                            guard_cnt <= '0;
                        end else begin
                            guard_cnt <= guard_cnt - GUARD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                endcase
            end
        end
    end

    // Route the owner's SPI signals to the flash; parked values when nobody owns it.
    always_comb begin
        bus.flash_cs_INV = 1'b1;
        bus.flash_clk    = 1'b0;
        bus.flash_mosi   = 1'b0;
        bus.dsp_miso     = 1'b1;
        bus.cpu_miso     = 1'b1;
        if (grant[0]) begin
            bus.flash_cs_INV = bus.dsp_cs_INV;
            bus.flash_clk    = bus.dsp_clk;
            bus.flash_mosi   = bus.dsp_mosi;
            bus.dsp_miso     = bus.flash_miso;
        end else if (grant[1]) begin
            bus.flash_cs_INV = bus.cpu_cs_INV;
            bus.flash_clk    = bus.cpu_clk;
            bus.flash_mosi   = bus.cpu_mosi;
            bus.cpu_miso     = bus.flash_miso;
        end
    end

endmodule
